regfile_writeback_stage: RTL and testbench



---
 rtl/rv32i_opcodes_pkg.sv | 26 ++
 rtl/rv_load_align.sv | 43 ++++
 rtl/regfile_writeback_stage.sv | 132 +++++++++++++
 tb/tb_regfile_writeback_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_opcodes_pkg.sv
// Shared encodings for the writeback stage: result-source select, load
// function codes and the writeback FSM states.
package rv32i_opcodes;

  typedef enum logic [1:0] {
    FROM_ALU       = 2'd0,
    FROM_MEM       = 2'd1,
    FROM_PC_PLUS_4 = 2'd2
  } regfile_load_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_funct_t;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/rv_load_align.sv
// Combinational load extractor: picks the addressed byte/half/word/dword out
// of an aligned memory word, moves it to bit 0 and sign- or zero-extends it.
module rv_load_align
  import rv32i_opcodes::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]               raw,
  input  logic [2:0]                     funct3,
  input  logic [$clog2(WIDTH/8)-1:0]     offset,
  output logic [WIDTH-1:0]               data
);

  localparam int OFF_W = $clog2(WIDTH/8);

  logic [OFF_W-1:0] off_h;
  logic [OFF_W-1:0] off_w;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_h;
  logic [WIDTH-1:0] sh_w;

  // Misaligned offsets never reach here, so the low bits are simply dropped.
  assign off_h = offset & ~OFF_W'(1);
  assign off_w = offset & ~OFF_W'(3);
  assign sh_b  = raw >> {offset, 3'b000};
  assign sh_h  = raw >> {off_h, 3'b000};
  assign sh_w  = raw >> {off_w, 3'b000};

  always_comb begin
    data = '0;
    case (funct3)
      LB:  data = WIDTH'($signed(sh_b[7:0]));
      LH:  data = WIDTH'($signed(sh_h[15:0]));
      LW:  data = WIDTH'($signed(sh_w[31:0]));
      LBU: data = WIDTH'(sh_b[7:0]);
      LHU: data = WIDTH'(sh_h[15:0]);
      LD:  if (WIDTH == 64) data = raw;
      LWU: if (WIDTH == 64) data = WIDTH'(sh_w[31:0]);
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/regfile_writeback_stage.sv
// Writeback stage: registers ALU / PC+4 results straight through and parks in
// WAIT_MEM for load responses, counting stall cycles and flagging stray responses.
module regfile_writeback_stage
  import rv32i_opcodes::*;
#(
  parameter int WIDTH       = 32,
  parameter int RADDR_W     = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [RADDR_W-1:0]          in_rd,
  input  regfile_load_t               in_src,
  input  logic [2:0]                  in_funct3,
  input  logic [$clog2(WIDTH/8)-1:0]  in_addr_lo,
  input  logic [WIDTH-1:0]            alu_out,
  input  logic [WIDTH-1:0]            pc_plus4,
  input  logic                        mem_rsp_valid,
  input  logic [WIDTH-1:0]            mem_rsp_data,
  output logic                        rf_wr_en,
  output logic [RADDR_W-1:0]          rf_wr_addr,
  output logic [WIDTH-1:0]            rf_wr_data,
  output logic [STALL_CNT_W-1:0]      stall_cnt,
  input  logic                        stall_clr,
  output logic                        rsp_err
);

  localparam int OFF_W = $clog2(WIDTH/8);
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  wb_state_t                state_q, state_d;
  logic                     rf_wr_en_q, rf_wr_en_d;
  logic [RADDR_W-1:0]       rf_wr_addr_q, rf_wr_addr_d;
  logic [WIDTH-1:0]         rf_wr_data_q, rf_wr_data_d;
  logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic                     rsp_err_q, rsp_err_d;
  logic [RADDR_W-1:0]       pend_rd_q, pend_rd_d;
  logic [2:0]               pend_f3_q, pend_f3_d;
  logic [OFF_W-1:0]         pend_off_q, pend_off_d;
  logic [WIDTH-1:0]         load_data;

  rv_load_align #(.WIDTH(WIDTH)) u_align (
    .raw    (mem_rsp_data),
    .funct3 (pend_f3_q),
    .offset (pend_off_q),
    .data   (load_data)
  );

  always_comb begin
    state_d      = state_q;
    rf_wr_en_d   = 1'b0;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    stall_cnt_d  = stall_cnt_q;
    rsp_err_d    = rsp_err_q;
    pend_rd_d    = pend_rd_q;
    pend_f3_d    = pend_f3_q;
    pend_off_d   = pend_off_q;
    case (state_q)
      WB_IDLE: begin
        if (mem_rsp_valid) rsp_err_d = 1'b1;
        if (in_valid) begin
          case (in_src)
            FROM_ALU: begin
              rf_wr_en_d   = (in_rd != '0);
              rf_wr_addr_d = in_rd;
              rf_wr_data_d = alu_out;
            end
            FROM_PC_PLUS_4: begin
              rf_wr_en_d   = (in_rd != '0);
              rf_wr_addr_d = in_rd;
              rf_wr_data_d = pc_plus4;
            end
            FROM_MEM: begin
              pend_rd_d  = in_rd;
              pend_f3_d  = in_funct3;
              pend_off_d = in_addr_lo;
              state_d    = WB_WAIT_MEM;
            end
            default: ;
          endcase
        end
      end
      WB_WAIT_MEM: begin
        if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
        if (mem_rsp_valid) begin
          rf_wr_en_d   = (pend_rd_q != '0);
          rf_wr_addr_d = pend_rd_q;
          rf_wr_data_d = load_data;
          state_d      = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
    if (stall_clr) stall_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WB_IDLE;
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      stall_cnt_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      stall_cnt_q  <= stall_cnt_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Pending-load fields are only meaningful while WAIT_MEM, so they carry no reset.
  always_ff @(posedge clk) begin
    pend_rd_q  <= pend_rd_d;
    pend_f3_q  <= pend_f3_d;
    pend_off_q <= pend_off_d;
  end

  assign in_ready   = (state_q == WB_IDLE);
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign stall_cnt  = stall_cnt_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_regfile_writeback_stage.sv
// Directed bench for regfile_writeback_stage: a 32-bit instance for the main
// sequencing and a 64-bit instance for the doubleword-only load types.
module tb_regfile_writeback_stage;
  import rv32i_opcodes::*;

  logic clk;
  logic rst_n;

  logic          in_valid, in_ready;
  logic [4:0]    in_rd;
  regfile_load_t in_src;
  logic [2:0]    in_funct3;
  logic [1:0]    in_addr_lo;
  logic [31:0]   alu_out, pc_plus4, mem_rsp_data, rf_wr_data;
  logic          mem_rsp_valid, rf_wr_en, stall_clr, rsp_err;
  logic [4:0]    rf_wr_addr;
  logic [15:0]   stall_cnt;

  logic          w_in_valid, w_in_ready;
  logic [4:0]    w_in_rd;
  regfile_load_t w_in_src;
  logic [2:0]    w_in_funct3;
  logic [2:0]    w_in_addr_lo;
  logic [63:0]   w_alu_out, w_pc_plus4, w_mem_rsp_data, w_rf_wr_data;
  logic          w_mem_rsp_valid, w_rf_wr_en, w_stall_clr, w_rsp_err;
  logic [4:0]    w_rf_wr_addr;
  logic [15:0]   w_stall_cnt;

  int checks = 0;
  int failures = 0;
  int ready_lo_cycles;

  regfile_writeback_stage #(.WIDTH(32), .RADDR_W(5), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_src(in_src), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .alu_out(alu_out), .pc_plus4(pc_plus4), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data), .stall_cnt(stall_cnt), .stall_clr(stall_clr),
    .rsp_err(rsp_err)
  );

  regfile_writeback_stage #(.WIDTH(64), .RADDR_W(5), .STALL_CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_rd(w_in_rd), .in_src(w_in_src), .in_funct3(w_in_funct3), .in_addr_lo(w_in_addr_lo),
    .alu_out(w_alu_out), .pc_plus4(w_pc_plus4), .mem_rsp_valid(w_mem_rsp_valid),
    .mem_rsp_data(w_mem_rsp_data), .rf_wr_en(w_rf_wr_en), .rf_wr_addr(w_rf_wr_addr),
    .rf_wr_data(w_rf_wr_data), .stall_cnt(w_stall_cnt), .stall_clr(w_stall_clr),
    .rsp_err(w_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Accept a load, stay `waits` cycles in WAIT_MEM (response in the last one).
  task automatic mem_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                          input logic [31:0] rsp, input int waits);
    in_valid = 1'b1; in_src = FROM_MEM; in_rd = rd; in_funct3 = f3; in_addr_lo = off;
    step();
    in_valid = 1'b0;
    ready_lo_cycles = 0;
    if (!in_ready) ready_lo_cycles++;
    chk("load_no_early_write", {63'd0, rf_wr_en}, 64'd0);
    for (int i = 1; i < waits; i++) begin
      step();
      if (!in_ready) ready_lo_cycles++;
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = rsp;
    step();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic mem_load64(input logic [2:0] f3, input logic [2:0] off, input logic [63:0] rsp);
    w_in_valid = 1'b1; w_in_src = FROM_MEM; w_in_rd = 5'd12; w_in_funct3 = f3; w_in_addr_lo = off;
    step();
    w_in_valid = 1'b0;
    w_mem_rsp_valid = 1'b1; w_mem_rsp_data = rsp;
    step();
    w_mem_rsp_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1; in_src = FROM_ALU; in_rd = 5'd5; in_funct3 = 3'd0; in_addr_lo = 2'd0;
    alu_out = 32'h1234; pc_plus4 = 32'h0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    stall_clr = 1'b0;
    w_in_valid = 1'b0; w_in_src = FROM_ALU; w_in_rd = 5'd0; w_in_funct3 = 3'd0;
    w_in_addr_lo = 3'd0; w_alu_out = 64'h0; w_pc_plus4 = 64'h0;
    w_mem_rsp_valid = 1'b0; w_mem_rsp_data = 64'h0; w_stall_clr = 1'b0;

    // Reset held with a request pending: nothing may be accepted.
    step(); step();
    chk("rst_wr_en", {63'd0, rf_wr_en}, 64'd0);
    chk("rst_wr_addr", {59'd0, rf_wr_addr}, 64'd0);
    chk("rst_wr_data", {32'd0, rf_wr_data}, 64'd0);
    chk("rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
    chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    rst_n = 1'b1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("alu_wr_en", {63'd0, rf_wr_en}, 64'd1);
    chk("alu_wr_addr", {59'd0, rf_wr_addr}, 64'd5);
    chk("alu_wr_data", {32'd0, rf_wr_data}, 64'h1234);
    in_valid = 1'b0;
    step();
    chk("alu_pulse_one_cycle", {63'd0, rf_wr_en}, 64'd0);
    chk("hold_wr_addr", {59'd0, rf_wr_addr}, 64'd5);
    chk("hold_wr_data", {32'd0, rf_wr_data}, 64'h1234);

    // Back-to-back ALU then PC+4.
    in_valid = 1'b1; in_src = FROM_ALU; in_rd = 5'd1; alu_out = 32'hA; pc_plus4 = 32'hBAD0;
    step();
    chk("b2b_alu_en", {63'd0, rf_wr_en}, 64'd1);
    chk("b2b_alu_addr", {59'd0, rf_wr_addr}, 64'd1);
    chk("b2b_alu_data", {32'd0, rf_wr_data}, 64'hA);
    chk("b2b_ready", {63'd0, in_ready}, 64'd1);
    in_src = FROM_PC_PLUS_4; in_rd = 5'd2; alu_out = 32'hDEAD; pc_plus4 = 32'h104;
    step();
    chk("b2b_pc_en", {63'd0, rf_wr_en}, 64'd1);
    chk("b2b_pc_addr", {59'd0, rf_wr_addr}, 64'd2);
    chk("b2b_pc_data", {32'd0, rf_wr_data}, 64'h104);
    in_valid = 1'b0;
    step();

    // LB with four WAIT_MEM cycles.
    mem_load(5'd7, 3'b000, 2'd3, 32'h80FF_0000, 4);
    chk("lb_ready_lo_cycles", 64'(ready_lo_cycles), 64'd4);
    chk("lb_stall_cnt", {48'd0, stall_cnt}, 64'd4);
    chk("lb_wr_en", {63'd0, rf_wr_en}, 64'd1);
    chk("lb_wr_addr", {59'd0, rf_wr_addr}, 64'd7);
    chk("lb_wr_data", {32'd0, rf_wr_data}, 64'hFFFF_FF80);
    chk("lb_ready_back", {63'd0, in_ready}, 64'd1);
    step();
    chk("lb_pulse_one_cycle", {63'd0, rf_wr_en}, 64'd0);

    stall_clr = 1'b1;
    step();
    chk("stall_clr", {48'd0, stall_cnt}, 64'd0);

    // Clear held through a stall: clear wins over increment.
    mem_load(5'd8, 3'b101, 2'd2, 32'h8001_0000, 3);
    chk("clr_wins", {48'd0, stall_cnt}, 64'd0);
    chk("lhu_data", {32'd0, rf_wr_data}, 64'h0000_8001);
    stall_clr = 1'b0;
    mem_load(5'd8, 3'b001, 2'd2, 32'h8001_0000, 1);
    chk("lh_data", {32'd0, rf_wr_data}, 64'hFFFF_8001);
    chk("min_path_stall", {48'd0, stall_cnt}, 64'd1);
    mem_load(5'd9, 3'b010, 2'd1, 32'h1234_5678, 1);
    chk("lw_rounded_off", {32'd0, rf_wr_data}, 64'h1234_5678);
    mem_load(5'd9, 3'b100, 2'd1, 32'h0000_A500, 2);
    chk("lbu_data", {32'd0, rf_wr_data}, 64'h0000_00A5);
    mem_load(5'd10, 3'b110, 2'd0, 32'hFFFF_FFFF, 1);
    chk("illegal_f3_en", {63'd0, rf_wr_en}, 64'd1);
    chk("illegal_f3_data", {32'd0, rf_wr_data}, 64'd0);
    step();

    // rd == 0 never writes.
    in_valid = 1'b1; in_src = FROM_ALU; in_rd = 5'd0; alu_out = 32'h77;
    step();
    in_valid = 1'b0;
    chk("rd0_alu_en", {63'd0, rf_wr_en}, 64'd0);
    mem_load(5'd0, 3'b010, 2'd0, 32'h5555_AAAA, 2);
    chk("rd0_lw_en", {63'd0, rf_wr_en}, 64'd0);
    chk("rd0_lw_idle", {63'd0, in_ready}, 64'd1);

    // Invalid source encoding is dropped.
    in_valid = 1'b1; in_src = regfile_load_t'(2'd3); in_rd = 5'd6;
    step();
    in_valid = 1'b0;
    chk("bad_src_en", {63'd0, rf_wr_en}, 64'd0);
    chk("bad_src_ready", {63'd0, in_ready}, 64'd1);

    // Stray response in IDLE alongside a real ALU request.
    in_valid = 1'b1; in_src = FROM_ALU; in_rd = 5'd3; alu_out = 32'h55;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_FFFF;
    step();
    in_valid = 1'b0; mem_rsp_valid = 1'b0;
    chk("stray_rsp_err", {63'd0, rsp_err}, 64'd1);
    chk("stray_alu_data", {32'd0, rf_wr_data}, 64'h55);
    step(); step();
    chk("rsp_err_sticky", {63'd0, rsp_err}, 64'd1);

    // Reset in the middle of WAIT_MEM.
    in_valid = 1'b1; in_src = FROM_MEM; in_rd = 5'd4; in_funct3 = 3'b010;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_stall", {48'd0, stall_cnt}, 64'd0);
    chk("midrst_err", {63'd0, rsp_err}, 64'd0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("midrst_no_write", {63'd0, rf_wr_en}, 64'd0);

    // 64-bit doubleword-only loads.
    mem_load64(3'b110, 3'd4, 64'hFFFF_FFFF_0000_0000);
    chk("w64_lwu", w_rf_wr_data, 64'h0000_0000_FFFF_FFFF);
    mem_load64(3'b010, 3'd4, 64'h8000_0000_0000_0000);
    chk("w64_lw_sext", w_rf_wr_data, 64'hFFFF_FFFF_8000_0000);
    mem_load64(3'b011, 3'd5, 64'h0123_4567_89AB_CDEF);
    chk("w64_ld", w_rf_wr_data, 64'h0123_4567_89AB_CDEF);
    mem_load64(3'b100, 3'd6, 64'h00C3_0000_0000_0000);
    chk("w64_lbu", w_rf_wr_data, 64'h0000_0000_0000_00C3);
    chk("w64_en", {63'd0, w_rf_wr_en}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
